// File: rtl/conv1d_window_seq.sv
// 5-deep sliding-window feeder that sweeps a 5:1 tap-select mux for a serial MAC.
// Optional macro CONV1D_WIN_ZERO_PAD_EN: leading zero padding (sweep on every sample).
module conv1d_window_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_last_i,
  output logic [WIDTH-1:0] tap1_o,
  output logic [WIDTH-1:0] tap2_o,
  output logic [WIDTH-1:0] tap3_o,
  output logic [WIDTH-1:0] tap4_o,
  output logic [WIDTH-1:0] tap5_o,
  output logic [2:0]       sel_o,
  output logic             tap_valid_o,
  input  logic             tap_ready_i,
  output logic             win_first_o,
  output logic             win_last_o,
  output logic             err_short_o
);

`ifdef CONV1D_WIN_ZERO_PAD_EN
  localparam logic [2:0] FillThresh = 3'd1;
`else
  localparam logic [2:0] FillThresh = 3'd5;
`endif

  typedef enum logic {StFill, StSweep} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tap_q [5];
  logic [WIDTH-1:0] tap_d [5];
  logic [2:0]       cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [2:0]       sel_q, sel_d;
  logic             tap_valid_q, tap_valid_d;
`ifndef CONV1D_WIN_ZERO_PAD_EN
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    sel_d       = sel_q;
    tap_valid_d = tap_valid_q;
`ifndef CONV1D_WIN_ZERO_PAD_EN
    err_d       = 1'b0;
`endif
    unique case (state_q)
      StFill: begin
        if (in_valid_i) begin
          tap_d[0] = tap_q[1];
          tap_d[1] = tap_q[2];
          tap_d[2] = tap_q[3];
          tap_d[3] = tap_q[4];
          tap_d[4] = in_data_i;
          cnt_d    = (cnt_q >= 3'd5) ? 3'd5 : cnt_q + 3'd1;
          last_d   = in_last_i;
          if (cnt_d >= FillThresh) begin
            state_d     = StSweep;
            sel_d       = 3'b100;
            tap_valid_d = 1'b1;
          end else if (in_last_i) begin
            // Short sequence: discard it entirely and flag the error.
            tap_d  = '{default: '0};
            cnt_d  = 3'd0;
            last_d = 1'b0;
`ifndef CONV1D_WIN_ZERO_PAD_EN
            err_d  = 1'b1;
`endif
          end
        end
      end
      StSweep: begin
        if (tap_ready_i) begin
          if (sel_q == 3'b000) begin
            state_d     = StFill;
            sel_d       = 3'b100;
            tap_valid_d = 1'b0;
            // End of sequence: start the next one from an empty window.
            if (last_q) begin
              tap_d  = '{default: '0};
              cnt_d  = 3'd0;
              last_d = 1'b0;
            end
          end else begin
            sel_d = sel_q - 3'd1;
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StFill;
      tap_q       <= '{default: '0};
      cnt_q       <= 3'd0;
      last_q      <= 1'b0;
      sel_q       <= 3'b100;
      tap_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      tap_valid_q <= tap_valid_d;
    end
  end

`ifndef CONV1D_WIN_ZERO_PAD_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err_short_o = err_q;
`else
  assign err_short_o = 1'b0;
`endif

  assign tap1_o      = tap_q[0];
  assign tap2_o      = tap_q[1];
  assign tap3_o      = tap_q[2];
  assign tap4_o      = tap_q[3];
  assign tap5_o      = tap_q[4];
  assign sel_o       = sel_q;
  assign tap_valid_o = tap_valid_q;
  assign in_ready_o  = (state_q == StFill);
  assign win_first_o = (state_q == StSweep) && (sel_q == 3'b100);
  assign win_last_o  = (state_q == StSweep) && (sel_q == 3'b000);

endmodule

// File: tb/tb_conv1d_window_seq.sv
// Self-checking bench for conv1d_window_seq: directed and random sequences vs. a window model.
module tb_conv1d_window_seq;

`ifdef CONV1D_WIN_ZERO_PAD_EN
  localparam bit Pad = 1'b1;
`else
  localparam bit Pad = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_data;
  logic [7:0] tap1, tap2, tap3, tap4, tap5;
  logic [2:0] sel;
  logic       tap_valid, tap_ready, win_first, win_last, err_short;

  int n_chk  = 0;
  int n_fail = 0;

  `define CHK(tag, obs, exp) \
    begin \
      n_chk++; \
      assert ((obs) === (exp)) else begin \
        n_fail++; \
        $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
      end \
    end

  conv1d_window_seq #(.WIDTH(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .tap1_o      (tap1),
    .tap2_o      (tap2),
    .tap3_o      (tap3),
    .tap4_o      (tap4),
    .tap5_o      (tap5),
    .sel_o       (sel),
    .tap_valid_o (tap_valid),
    .tap_ready_i (tap_ready),
    .win_first_o (win_first),
    .win_last_o  (win_last),
    .err_short_o (err_short)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sel;
    logic       first;
    logic       last;
    logic [7:0] data;
  } hs_t;

  hs_t hs_q[$];
  int  seq_q[$];
  int  err_cnt, busy_cnt, stall_viol;
  int  rdy_mode = 0;
  int  pidx     = 0;
  bit  pat [8]  = '{1, 0, 0, 1, 1, 0, 1, 1};

  function automatic logic [7:0] mux_tap(input logic [2:0] s);
    case (s)
      3'b100:  return tap1;
      3'b011:  return tap2;
      3'b010:  return tap3;
      3'b001:  return tap4;
      default: return tap5;
    endcase
  endfunction

  // Monitor: record every tap handshake, error pulses, busy cycles and stall holds.
  initial begin
    logic       prev_stall;
    logic [2:0] prev_sel;
    prev_stall = 1'b0;
    prev_sel   = 3'b100;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tap_valid && tap_ready) hs_q.push_back({sel, win_first, win_last, mux_tap(sel)});
        if (err_short) err_cnt++;
        if (!in_ready) busy_cnt++;
        if (prev_stall && sel !== prev_sel) stall_viol++;
        prev_stall = tap_valid && !tap_ready;
        prev_sel   = sel;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // MAC-side ready: 0 = always ready, 1 = random, 2 = fixed toggle pattern per tap-valid cycle.
  initial begin
    tap_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: tap_ready = 1'b1;
        1: tap_ready = 1'($urandom_range(0, 1));
        default: begin
          if (tap_valid && pidx < 8) begin
            tap_ready = pat[pidx];
            pidx++;
          end else begin
            tap_ready = 1'b1;
          end
        end
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] d, input logic l);
    int w;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    w = 0;
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    `CHK("accept_timeout", (w < 300), 1'b1)
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Expected windows derived from the sample list: consecutive 5-sample slices, or
  // one window per sample with leading zeros when padding is enabled.
  task automatic run_seq(input int mode, input bit gaps, input bit chk_lat, input int extra);
    int n, nwin, e, w;
    logic [7:0] ev;
    hs_q.delete();
    err_cnt    = 0;
    busy_cnt   = 0;
    stall_viol = 0;
    pidx       = 0;
    rdy_mode   = mode;
    n = seq_q.size();
    for (int i = 0; i < n; i++) begin
      send(8'(seq_q[i]), (i == n - 1));
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    if (chk_lat) begin
      `CHK("lat_tap_valid", tap_valid, 1'b1)
      `CHK("lat_sel", sel, 3'b100)
      `CHK("lat_first", win_first, 1'b1)
      `CHK("lat_in_ready", in_ready, 1'b0)
    end
    w = 0;
    while (!(in_ready && !tap_valid) && w < 400) begin
      @(negedge clk);
      w++;
    end
    `CHK("drain_timeout", (w < 400), 1'b1)
    repeat (2) @(negedge clk);
    nwin = Pad ? n : ((n >= 5) ? n - 4 : 0);
    `CHK("tap_handshakes", hs_q.size(), nwin * 5)
    for (int k = 0; k < nwin; k++) begin
      e = Pad ? k : k + 4;
      for (int j = 0; j < 5; j++) begin
        if (k * 5 + j < hs_q.size()) begin
          ev = (e - 4 + j >= 0) ? 8'(seq_q[e - 4 + j]) : 8'h00;
          `CHK("tap_data", hs_q[k * 5 + j].data, ev)
          `CHK("tap_sel", hs_q[k * 5 + j].sel, 3'(4 - j))
          `CHK("tap_first", hs_q[k * 5 + j].first, (j == 0))
          `CHK("tap_last", hs_q[k * 5 + j].last, (j == 4))
        end
      end
    end
    `CHK("err_pulses", err_cnt, (!Pad && n < 5) ? 1 : 0)
    `CHK("stall_hold", stall_viol, 0)
    if (extra >= 0) `CHK("busy_cycles", busy_cnt, 5 * nwin + extra)
    `CHK("taps_cleared", {tap1, tap2, tap3, tap4, tap5}, 40'h0)
  endtask

  initial begin
    int w;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    `CHK("rst_taps", {tap1, tap2, tap3, tap4, tap5}, 40'h0)
    `CHK("rst_sel", sel, 3'b100)
    `CHK("rst_tap_valid", tap_valid, 1'b0)
    `CHK("rst_first", win_first, 1'b0)
    `CHK("rst_last", win_last, 1'b0)
    `CHK("rst_err", err_short, 1'b0)
    `CHK("rst_in_ready", in_ready, 1'b1)
    rst = 1'b0;
    @(negedge clk);

    // One exact window.
    seq_q = '{1, 2, 3, 4, 5};
    run_seq(0, 1'b0, 1'b1, 0);

    // Overlapping windows.
    seq_q = '{1, 2, 3, 4, 5, 6, 7};
    run_seq(0, 1'b0, 1'b0, 0);

    // MAC stalls: 3 zero cycles in the ready pattern add 3 busy cycles.
    seq_q = '{11, 22, 33, 44, 55};
    run_seq(2, 1'b0, 1'b0, 3);

    // Short sequence, then a fresh one.
    seq_q = '{10, 20, 30};
    run_seq(0, 1'b0, 1'b0, 0);
    seq_q = '{1, 2, 3, 4, 5};
    run_seq(0, 1'b1, 1'b0, 0);

    // Zero-pad directed case (still meaningful as a short sequence without padding).
    seq_q = '{7, 8};
    run_seq(0, 1'b0, 1'b0, 0);

    // Random sequences with random MAC backpressure.
    for (int r = 0; r < 6; r++) begin
      seq_q.delete();
      for (int i = 0; i < $urandom_range(1, 10); i++) seq_q.push_back($urandom_range(0, 255));
      run_seq(1, 1'b1, 1'b0, -1);
    end

    // Reset in the middle of a sweep.
    rdy_mode = 0;
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0);
    w = 0;
    while (!(tap_valid && sel == 3'b010) && w < 50) begin
      @(negedge clk);
      w++;
    end
    `CHK("midsweep_reach", (w < 50), 1'b1)
    #2 rst = 1'b1;
    #1;
    `CHK("mrst_tap_valid", tap_valid, 1'b0)
    `CHK("mrst_taps", {tap1, tap2, tap3, tap4, tap5}, 40'h0)
    `CHK("mrst_sel", sel, 3'b100)
    `CHK("mrst_in_ready", in_ready, 1'b1)
    @(negedge clk);
    rst = 1'b0;
    hs_q.delete();
    for (int i = 1; i <= 4; i++) send(8'(40 + i), 1'b0);
    repeat (10) @(negedge clk);
    `CHK("post_reset_windows", hs_q.size(), Pad ? 20 : 0)

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv1d_window_seq.md
Name: conv1d_window_seq

Overview:
- Upstream feeder for the 5:1 tap-select mux in the conv1d datapath.
- Accepts a sample stream over valid/ready and keeps a 5-deep sliding window in registers.
- For each complete window, sequences the mux select through all five taps, one per cycle, handshaking with the downstream serial MAC.
- Marks the first and last tap of each window so the MAC can clear and emit its accumulator.

Parameters:
- WIDTH, 8, sample and tap bit width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- in_valid_i  in  1  input sample valid.
- in_ready_o  out  1  block can accept a sample.
- in_data_i  in  WIDTH  input sample.
- in_last_i  in  1  final sample of the current sequence; qualified by the input handshake.
- tap1_o..tap5_o  out  WIDTH each  window registers. tap1 = oldest x[n-4]; tap5 = newest x[n].
- sel_o  out  3  mux select: 3'b100 = tap1, 3'b011 = tap2, 3'b010 = tap3, 3'b001 = tap4, 3'b000 = tap5.
- tap_valid_o  out  1  sel_o addresses a valid tap for the MAC.
- tap_ready_i  in  1  MAC consumes the current tap.
- win_first_o  out  1  current tap is the first of its window (sel_o = 3'b100).
- win_last_o  out  1  current tap is the last of its window (sel_o = 3'b000).
- err_short_o  out  1  one-cycle pulse: sequence ended with fewer than 5 samples.

Behaviour:
- Reset values: all taps 0, sel_o = 3'b100, tap_valid_o = 0, win_first_o = 0, win_last_o = 0, err_short_o = 0, in_ready_o = 1. FSM state FILL, fill count 0, last flag 0. Reset mid-sweep aborts the window and produces no further taps.
- FSM has two states: FILL and SWEEP.
- FILL:
  - in_ready_o = 1.
  - On accept: tap1<=tap2, tap2<=tap3, tap3<=tap4, tap4<=tap5, tap5<=in_data_i.
  - Fill count increments and saturates at 5; in_last_i is captured into the last flag.
  - If the post-accept count is 5: go to SWEEP with sel_o = 3'b100.
  - Otherwise, if in_last_i was set: clear taps and count, pulse err_short_o next cycle, stay in FILL.
- SWEEP:
  - in_ready_o = 0 and tap_valid_o = 1.
  - win_first_o = (sel_o == 3'b100); win_last_o = (sel_o == 3'b000).
  - On tap_valid_o & tap_ready_i: sel_o decrements.
  - When sel_o = 0 is accepted: go to FILL and reset sel_o to 3'b100.
  - If the last flag is set: taps, count and last flag are cleared in that same cycle, starting a new sequence.
  - If tap_ready_i = 0: sel_o and taps hold (stall). tap_valid_o never drops mid-window.
- Latency and throughput:
  - Accepting the 5th sample at cycle t gives tap_valid_o = 1 with sel_o = 3'b100 at t+1.
  - With tap_ready_i held high, steady state is one output window per 6 cycles: 1 accept cycle plus 5 sweep cycles.
- Window counts:
  - A sequence of N >= 5 samples yields N-4 windows.
  - Windows overlap: taps shift by one sample between windows.
- Boundary conditions:
  - in_valid_i while in SWEEP is ignored and must be held by the source.
  - in_last_i on the 5th sample yields exactly one window.
  - A new sequence can be accepted in the cycle after the final tap handshake.
- All outputs are registered except in_ready_o, win_first_o and win_last_o, which decode from state and sel_o.

Optional Feature:
- Macro: CONV1D_WIN_ZERO_PAD_EN.
- Defined: leading zero padding. The fill threshold is 1, so every accepted sample, including the first, triggers a sweep. Taps not yet filled read 0 (cleared at sequence start). A sequence of N samples yields N windows, and err_short_o is tied to 0.
- Undefined: behaviour exactly as specified above (threshold 5, N-4 windows, err_short_o active).

Test Plan:
- Reset, then feed 1,2,3,4,5 with in_last on 5 and tap_ready=1 -> one window. sel_o goes 4,3,2,1,0 on consecutive cycles, presenting taps 1,2,3,4,5. win_first on the first tap cycle, win_last on the fifth. Taps cleared after the window.
- Stream 1..7 with last on 7, ready=1 -> 3 windows: (1..5), (2..6), (3..7). in_ready_o low for 5 cycles after each of samples 5, 6 and 7.
- Send 5 samples, then toggle tap_ready 1,0,0,1,1,0,1,1 -> sel_o holds during each 0. Exactly 5 tap handshakes occur. in_ready returns high only after the sel=0 handshake.
- Send 10, 20, 30 with last on 30 -> no tap_valid. err_short_o pulses once. A following sequence 1..5 produces a window containing only new data.
- Assert rst_i mid-sweep with sel_o = 3'b010 -> tap_valid_o = 0, taps = 0, sel_o = 3'b100, in_ready_o = 1. The next 4 samples produce no window.
- With CONV1D_WIN_ZERO_PAD_EN defined, feed 7, 8 with last on 8 -> 2 windows: (0,0,0,0,7) and (0,0,0,7,8). err_short_o stays 0.
